// File: rtl/ippcrc_crc32_chk32.sv
// ---------------------------------------------------------------------------
// ippcrc_crc32_chk32
// Receive-side CRC-32 checker for 32-bit word streams. It accumulates
// CRC-32 (poly 0x04C11DB7, each word bit-reversed on entry) over the payload
// words of a frame. It then compares the result with the FCS carried in the
// frame's last word. The stream is forwarded through one register stage. A
// verdict is reported per frame, and framing errors are flagged.
//
// Optional feature macro: IPPCRC_CHK32_STAT_EN (adds good/bad verdict counters)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_vld      input word valid
//   i_sop      first word of frame (qualified by i_vld)
//   i_eop      last word of frame, carries the FCS (qualified by i_vld)
//   i_dat      input word
//   o_vld      registered i_vld, only for words accepted into a frame
//   o_sop      registered i_sop
//   o_eop      registered i_eop
//   o_dat      registered i_dat
//   chk_vld    one-cycle pulse, frame verdict valid
//   chk_ok     frame passed (valid with chk_vld)
//   chk_err    {abort, len_err, crc_err} (valid with chk_vld)
//   orph       one-cycle pulse, a word outside any frame was dropped
//   pld_cnt    payload word count of the reported frame (saturates at 255)
//   stat_clr   (STAT_EN only) synchronous clear of the verdict counters
//   stat_good  (STAT_EN only) saturating count of passing verdicts
//   stat_bad   (STAT_EN only) saturating count of failing verdicts
// ---------------------------------------------------------------------------
module ippcrc_crc32_chk32 #(
    parameter int          MIN_PLD  = 1,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vld,
    input  logic        i_sop,
    input  logic        i_eop,
    input  logic [31:0] i_dat,
    output logic        o_vld,
    output logic        o_sop,
    output logic        o_eop,
    output logic [31:0] o_dat,
    output logic        chk_vld,
    output logic        chk_ok,
    output logic [2:0]  chk_err,
    output logic        orph,
`ifdef IPPCRC_CHK32_STAT_EN
    input  logic        stat_clr,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad,
`endif
    output logic [7:0]  pld_cnt
);

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef enum logic {IDLE, BODY} state_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = d[31-i];
        return r;
    endfunction

    // 32-bit parallel CRC step. The whole word is folded in first. Then 32
    // zero-input shifts are applied. Because the CRC is linear, this equals
    // the bit-serial feed of the word.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] dat);
        logic [31:0] x;
        x = crc ^ bitrev32(dat);
        for (int i = 0; i < 32; i++) x = x[31] ? ((x << 1) ^ POLY) : (x << 1);
        return x;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        acc;
    logic        vrd;
    logic        v_abort;
    logic        v_crcerr;
    logic        v_lenerr;
    logic        v_ok;
    logic [7:0]  v_cnt;
    logic        orph_d;
    logic [31:0] fcs_exp;
    logic [7:0]  cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fcs_exp = ~bitrev32((state_q == BODY) ? crc_q : CRC_INIT);
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // A sop seen inside BODY aborts the running frame. The same word then
    // opens a new frame. If that word is also eop, the one-word frame only
    // reports the abort, because a cycle can carry only one verdict.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        acc      = 1'b0;
        vrd      = 1'b0;
        v_abort  = 1'b0;
        v_crcerr = 1'b0;
        v_cnt    = cnt_q;
        orph_d   = 1'b0;
        if (i_vld) begin
            if (i_sop) begin
                acc = 1'b1;
                if (state_q == BODY) begin
                    vrd     = 1'b1;
                    v_abort = 1'b1;
                    v_cnt   = cnt_q;
                end else if (i_eop) begin
                    vrd      = 1'b1;
                    v_crcerr = (i_dat != fcs_exp);
                    v_cnt    = 8'd0;
                end
                if (i_eop) begin
                    state_d = IDLE;
                    crc_d   = CRC_INIT;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = BODY;
                    crc_d   = crc_step(CRC_INIT, i_dat);
                    cnt_d   = 8'd1;
                end
            end else if (state_q == BODY) begin
                acc = 1'b1;
                if (i_eop) begin
                    vrd      = 1'b1;
                    v_crcerr = (i_dat != fcs_exp);
                    v_cnt    = cnt_q;
                    state_d  = IDLE;
                    crc_d    = CRC_INIT;
                    cnt_d    = 8'd0;
                end else begin
                    crc_d = crc_step(crc_q, i_dat);
                    cnt_d = cnt_inc;
                end
            end else begin
                orph_d = 1'b1;
            end
        end
    end

    // An aborted frame is reported only as an abort. It carries no length
    // or CRC error.
    always_comb begin
        v_lenerr = 1'b0;
        if (!v_abort) v_lenerr = (int'({24'd0, v_cnt}) < MIN_PLD);
        v_ok = vrd && !v_abort && !v_crcerr && !v_lenerr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld   <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_dat   <= 32'd0;
            chk_vld <= 1'b0;
            chk_ok  <= 1'b0;
            chk_err <= 3'b000;
            orph    <= 1'b0;
            pld_cnt <= 8'd0;
        end else begin
            o_vld   <= acc;
            o_sop   <= acc & i_sop;
            o_eop   <= acc & i_eop;
            o_dat   <= i_dat;
            chk_vld <= vrd;
            chk_ok  <= v_ok;
            chk_err <= vrd ? {v_abort, v_lenerr, v_crcerr} : 3'b000;
            orph    <= orph_d;
            if (vrd) pld_cnt <= v_cnt;
        end
    end

`ifdef IPPCRC_CHK32_STAT_EN
    // The clear takes priority over a verdict that arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good <= 16'd0;
            stat_bad  <= 16'd0;
        end else if (stat_clr) begin
            stat_good <= 16'd0;
            stat_bad  <= 16'd0;
        end else if (vrd) begin
            if (v_ok) begin
                if (stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
            end else begin
                if (stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ippcrc_crc32_chk32.sv
// ---------------------------------------------------------------------------
// tb_ippcrc_crc32_chk32
// Directed bench for the CRC-32 checker. Two instances share one input
// stream: u_dut uses MIN_PLD=0 and u_dut4 uses MIN_PLD=4. A frame can then be
// judged against both length limits at once. FCS values come from a
// reflected (LSB-first, poly 0xEDB88320) bit-serial CRC-32 reference.
// ---------------------------------------------------------------------------
module tb_ippcrc_crc32_chk32;

    logic        clk;
    logic        rst_n;
    logic        i_vld;
    logic        i_sop;
    logic        i_eop;
    logic [31:0] i_dat;

    logic        o_vld, o_sop, o_eop, chk_vld, chk_ok, orph;
    logic [31:0] o_dat;
    logic [2:0]  chk_err;
    logic [7:0]  pld_cnt;

    logic        o_vld4, o_sop4, o_eop4, chk_vld4, chk_ok4, orph4;
    logic [31:0] o_dat4;
    logic [2:0]  chk_err4;
    logic [7:0]  pld_cnt4;

`ifdef IPPCRC_CHK32_STAT_EN
    logic        stat_clr;
    logic [15:0] stat_good, stat_bad, stat_good4, stat_bad4;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] W0 = 32'h01020304;
    localparam logic [31:0] W1 = 32'hA5A5A5A5;
    localparam logic [31:0] W2 = 32'hDEADBEEF;
    localparam logic [31:0] FCS_ZERO_WORD = 32'h2144DF1C;

    ippcrc_crc32_chk32 #(.MIN_PLD(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop), .i_dat(i_dat),
        .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop), .o_dat(o_dat),
        .chk_vld(chk_vld), .chk_ok(chk_ok), .chk_err(chk_err), .orph(orph),
`ifdef IPPCRC_CHK32_STAT_EN
        .stat_clr(stat_clr), .stat_good(stat_good), .stat_bad(stat_bad),
`endif
        .pld_cnt(pld_cnt)
    );

    ippcrc_crc32_chk32 #(.MIN_PLD(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop), .i_dat(i_dat),
        .o_vld(o_vld4), .o_sop(o_sop4), .o_eop(o_eop4), .o_dat(o_dat4),
        .chk_vld(chk_vld4), .chk_ok(chk_ok4), .chk_err(chk_err4), .orph(orph4),
`ifdef IPPCRC_CHK32_STAT_EN
        .stat_clr(stat_clr), .stat_good(stat_good4), .stat_bad(stat_bad4),
`endif
        .pld_cnt(pld_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reflected CRC-32 reference: the word is consumed LSB first.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int i = 0; i < 32; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] ref_fcs3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return ~ref_crc(ref_crc(ref_crc(32'hFFFFFFFF, a), b), c);
    endfunction

    // Drives one input cycle at the falling edge. The DUT outputs are
    // registered, so right after this call they still show the previous cycle.
    task automatic put(input logic v, input logic s, input logic e, input logic [31:0] d);
        @(negedge clk);
        i_vld = v;
        i_sop = s;
        i_eop = e;
        i_dat = d;
    endtask

    task automatic test_reset();
        if ({o_vld, o_sop, o_eop, o_dat, chk_vld, chk_ok, chk_err, orph, pld_cnt} !== 48'd0) begin
            $display("[TB] FAIL reset_outputs got %h exp 0",
                     {o_vld, o_sop, o_eop, o_dat, chk_vld, chk_ok, chk_err, orph, pld_cnt});
            errors++;
        end
        checks++;
    endtask

    task automatic test_zero_payload();
        put(1, 1, 1, 32'h00000000);
        put(0, 0, 0, 32'h0);
        if ({chk_vld, chk_ok, chk_err, pld_cnt} !== {1'b1, 1'b1, 3'b000, 8'd0}) begin
            $display("[TB] FAIL zero_pld got %b exp 1_1_000_00000000", {chk_vld, chk_ok, chk_err, pld_cnt});
            errors++;
        end
        checks++;
        if ({chk_vld4, chk_ok4, chk_err4} !== {1'b1, 1'b0, 3'b010}) begin
            $display("[TB] FAIL zero_pld_min4 got %b exp 1_0_010", {chk_vld4, chk_ok4, chk_err4});
            errors++;
        end
        checks++;
    endtask

    // Valid 3-word frame with idle gaps. o_dat must follow i_dat by one
    // cycle throughout.
    task automatic test_good_frame();
        logic        sv[8];
        logic        ss[8];
        logic        se[8];
        logic [31:0] sd[8];
        sv = '{1, 0, 1, 0, 0, 1, 1, 0};
        ss = '{1, 0, 0, 0, 0, 0, 0, 0};
        se = '{0, 0, 0, 0, 0, 0, 1, 0};
        sd = '{W0, 32'hCAFE0000, W1, 32'h0BADF00D, 32'h77777777, W2, ref_fcs3(W0, W1, W2), 32'h0};
        for (int k = 0; k < 8; k++) begin
            put(sv[k], ss[k], se[k], sd[k]);
            if (k > 0) begin
                if ({o_vld, o_dat} !== {sv[k-1], sd[k-1]}) begin
                    $display("[TB] FAIL fwd_step%0d got %b/%h exp %b/%h", k, o_vld, o_dat, sv[k-1], sd[k-1]);
                    errors++;
                end
                checks++;
                if (k < 7 && chk_vld !== 1'b0) begin
                    $display("[TB] FAIL early_verdict_step%0d got %b exp 0", k, chk_vld);
                    errors++;
                end
                if (k < 7) checks++;
            end
        end
        if ({chk_vld, chk_ok, chk_err, pld_cnt, o_eop} !== {1'b1, 1'b1, 3'b000, 8'd3, 1'b1}) begin
            $display("[TB] FAIL good_frame got %b exp 1_1_000_00000011_1", {chk_vld, chk_ok, chk_err, pld_cnt, o_eop});
            errors++;
        end
        checks++;
        if ({chk_vld4, chk_ok4, chk_err4, pld_cnt4} !== {1'b1, 1'b0, 3'b010, 8'd3}) begin
            $display("[TB] FAIL len_err_min4 got %b exp 1_0_010_00000011", {chk_vld4, chk_ok4, chk_err4, pld_cnt4});
            errors++;
        end
        checks++;
    endtask

    task automatic test_crc_err();
        put(1, 1, 0, W0);
        put(1, 0, 0, W1 ^ 32'h1);
        put(1, 0, 0, W2);
        put(1, 0, 1, ref_fcs3(W0, W1, W2));
        put(0, 0, 0, 32'h0);
        if ({chk_vld, chk_ok, chk_err} !== {1'b1, 1'b0, 3'b001}) begin
            $display("[TB] FAIL crc_err got %b exp 1_0_001", {chk_vld, chk_ok, chk_err});
            errors++;
        end
        checks++;
    endtask

    task automatic test_abort();
        put(1, 1, 0, W0);
        put(1, 0, 0, W1);
        put(1, 1, 0, 32'h00000000);
        put(1, 0, 1, FCS_ZERO_WORD);
        if ({chk_vld, chk_ok, chk_err, pld_cnt, o_eop, o_sop} !== {1'b1, 1'b0, 3'b100, 8'd2, 1'b0, 1'b1}) begin
            $display("[TB] FAIL abort got %b exp 1_0_100_00000010_0_1", {chk_vld, chk_ok, chk_err, pld_cnt, o_eop, o_sop});
            errors++;
        end
        checks++;
        put(0, 0, 0, 32'h0);
        if ({chk_vld, chk_ok, chk_err, pld_cnt} !== {1'b1, 1'b1, 3'b000, 8'd1}) begin
            $display("[TB] FAIL after_abort got %b exp 1_1_000_00000001", {chk_vld, chk_ok, chk_err, pld_cnt});
            errors++;
        end
        checks++;
    endtask

    task automatic test_orphan();
        put(1, 0, 0, 32'h12345678);
        put(0, 0, 0, 32'h0);
        if ({orph, o_vld, chk_vld} !== 3'b100) begin
            $display("[TB] FAIL orphan got %b exp 100", {orph, o_vld, chk_vld});
            errors++;
        end
        checks++;
        put(0, 0, 0, 32'h0);
        if (orph !== 1'b0) begin
            $display("[TB] FAIL orphan_pulse got %b exp 0", orph);
            errors++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        put(1, 1, 0, 32'h00000000);
        put(1, 0, 1, FCS_ZERO_WORD);
        put(1, 1, 0, W0);
        if ({chk_vld, chk_ok, pld_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            $display("[TB] FAIL b2b_first got %b exp 1_1_00000001", {chk_vld, chk_ok, pld_cnt});
            errors++;
        end
        checks++;
        put(1, 0, 0, W1);
        put(1, 0, 0, W2);
        put(1, 0, 1, ref_fcs3(W0, W1, W2));
        put(0, 0, 0, 32'h0);
        if ({chk_vld, chk_ok, chk_err, pld_cnt} !== {1'b1, 1'b1, 3'b000, 8'd3}) begin
            $display("[TB] FAIL b2b_second got %b exp 1_1_000_00000011", {chk_vld, chk_ok, chk_err, pld_cnt});
            errors++;
        end
        checks++;
    endtask

    // Reset mid-frame: the outputs clear at once, and the partial frame is
    // forgotten. A following eop word is then an orphan.
    task automatic test_reset_midframe();
        put(1, 1, 0, W0);
        put(1, 0, 0, W1);
        @(negedge clk);
        rst_n = 1'b0;
        i_vld = 1'b0;
        #1;
        if ({o_vld, o_sop, o_dat, chk_vld, orph} !== 36'd0) begin
            $display("[TB] FAIL reset_async got %h exp 0", {o_vld, o_sop, o_dat, chk_vld, orph});
            errors++;
        end
        checks++;
        put(0, 0, 0, 32'h0);
        rst_n = 1'b1;
        put(1, 0, 1, ref_fcs3(W0, W1, W2));
        put(0, 0, 0, 32'h0);
        if ({orph, o_vld, chk_vld} !== 3'b100) begin
            $display("[TB] FAIL reset_discard got %b exp 100", {orph, o_vld, chk_vld});
            errors++;
        end
        checks++;
    endtask

`ifdef IPPCRC_CHK32_STAT_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        put(0, 0, 0, 32'h0);
        stat_clr = 1'b0;
        for (int i = 0; i < 7; i++) put(1, 1, 1, (i < 5) ? 32'h0 : 32'h1);
        put(0, 0, 0, 32'h0);
        if ({stat_good, stat_bad} !== {16'd5, 16'd2}) begin
            $display("[TB] FAIL stat_counts got %0d/%0d exp 5/2", stat_good, stat_bad);
            errors++;
        end
        checks++;
        stat_clr = 1'b1;
        put(1, 1, 1, 32'h0);
        put(0, 0, 0, 32'h0);
        stat_clr = 1'b0;
        if ({chk_vld, stat_good, stat_bad} !== {1'b1, 16'd0, 16'd0}) begin
            $display("[TB] FAIL stat_clr_wins got %b/%0d/%0d exp 1/0/0", chk_vld, stat_good, stat_bad);
            errors++;
        end
        checks++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        i_vld = 1'b0;
        i_sop = 1'b0;
        i_eop = 1'b0;
        i_dat = 32'h0;
`ifdef IPPCRC_CHK32_STAT_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        put(0, 0, 0, 32'h0);
        test_zero_payload();
        test_good_frame();
        test_crc_err();
        test_abort();
        test_orphan();
        test_back_to_back();
        test_reset_midframe();
`ifdef IPPCRC_CHK32_STAT_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
